// File: rtl/enc_seg_pkg.sv
// Shared constants and types for the encoder-result seven-segment scanner.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package enc_seg_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic       vld;
        logic       any;
        logic [2:0] code;
    } entry_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;

endpackage

// File: rtl/seg_glyph.sv
// Combinational code-to-glyph lookup; dp bit is always returned off (1).
// A result with no encoder bit set shows a dash instead of a digit.
module seg_glyph
    import enc_seg_pkg::*;
(
    input  logic       any_i,
    input  logic [2:0] code_i,
    output logic [7:0] pat_o
);

    always_comb begin
        pat_o = SEG_DASH;
        if (any_i) begin
            case (code_i)
                3'd0:    pat_o = GLYPH_0;
                3'd1:    pat_o = GLYPH_1;
                3'd2:    pat_o = GLYPH_2;
                3'd3:    pat_o = GLYPH_3;
                3'd4:    pat_o = GLYPH_4;
                3'd5:    pat_o = GLYPH_5;
                3'd6:    pat_o = GLYPH_6;
                default: pat_o = GLYPH_7;
            endcase
        end
    end

endmodule

// File: rtl/enc_seg_scan.sv
// Captures priority-encoder results into a 4-deep history and scans them
// onto a 4-digit multiplexed seven-segment display (newest on digit 0).
module enc_seg_scan
    import enc_seg_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int HOLD     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_any,
    input  logic       clr,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [7:0] acc_cnt
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int HLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [HLD_W-1:0] HOLD_LOAD = HLD_W'(HOLD - 1);

    state_e           state_q, state_d;
    logic [HLD_W-1:0] hold_q, hold_d;
    entry_t           hist_q [4];
    entry_t           hist_d [4];
    logic [7:0]       acc_q, acc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       dig_q, dig_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic             accept;
    entry_t           sel;
    logic [7:0]       pat;

    // rst is the raw pin so in_ready reads low throughout reset
    assign in_ready = rst & ~clr & (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;

    assign sel = hist_q[dig_q];

    seg_glyph u_glyph (
        .any_i  (sel.any),
        .code_i (sel.code),
        .pat_o  (pat)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        acc_d   = acc_q;
        for (int i = 0; i < 4; i++) hist_d[i] = hist_q[i];

        if (clr) begin
            for (int i = 0; i < 4; i++) hist_d[i].vld = 1'b0;
            state_d = ST_IDLE;
            hold_d  = '0;
            acc_d   = 8'd0;
        end else if (accept) begin
            for (int i = 3; i > 0; i--) hist_d[i] = hist_q[i-1];
            hist_d[0] = '{vld: 1'b1, any: in_any, code: in_code};
            state_d   = ST_HOLD;
            hold_d    = HOLD_LOAD;
            acc_d     = acc_q + 8'd1;
        end else if (state_q == ST_HOLD) begin
            if (hold_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    // Scan timing runs freely; neither accept nor clr disturbs it
    always_comb begin
        div_d = div_q + 1'b1;
        dig_d = dig_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            dig_d = dig_q + 2'd1;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        if (sel.vld) begin
            seg_d = {pat[7] & (dig_q != 2'd0), pat[6:0]};
        end
        an_d = ~(4'b0001 << dig_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            acc_q   <= 8'd0;
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            div_q   <= '0;
            dig_q   <= 2'd0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'b1110;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            acc_q   <= acc_d;
            for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
            div_q   <= div_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign acc_cnt = acc_q;

endmodule

// File: doc/enc_seg_scan.md
ENC_SEG_SCAN -- requirements
Module: enc_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles each digit stays lit (min 2).
REQ-002 SHALL have parameter HOLD, default 4: cycles in_ready stays low after each accept (min 1).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-005 SHALL have port in_valid  input  1  upstream encoder result present.
REQ-006 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-007 SHALL have port in_code  input  3  encoded index 0..7 from the priority encoder.
REQ-008 SHALL have port in_any  input  1  1 = at least one encoder input bit was set.
REQ-009 SHALL have port clr  input  1  synchronous history clear.
REQ-010 SHALL have port seg  output  8  {dp,g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port an  output  4  digit enables, active-low, one-hot-low.
REQ-012 SHALL have port acc_cnt  output  8  number of accepted results, modulo 256.

Function
REQ-013 SHALL transfer a result only in a cycle where in_valid=1 and in_ready=1 (accept).
REQ-014 SHALL keep a 4-entry history, each entry {vld, any, code}; entry 0 is newest.
REQ-015 On accept SHALL shift entry i to i+1 (entry 3 discarded) and load {1, in_any, in_code} into entry 0, visible the next cycle.
REQ-016 SHALL run a two-state FSM: IDLE (in_ready=1) and HOLD (in_ready=0).
REQ-017 IDLE -> HOLD on accept, loading hold counter with HOLD-1; HOLD decrements each cycle and returns to IDLE the cycle after it reads 0, so in_ready is low for exactly HOLD cycles.
REQ-018 in_ready SHALL be driven 0 whenever clr=1, regardless of state.
REQ-019 clr=1 SHALL invalidate all 4 entries, force FSM to IDLE, and clear acc_cnt next cycle; no accept occurs in that cycle.
REQ-020 acc_cnt SHALL increment by 1 per accept and wrap 255 -> 0.
REQ-021 SHALL run a scan divider 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and the 2-bit digit index increments, wrapping 3 -> 0.
REQ-022 Digit index and divider SHALL be unaffected by accept and clr.
REQ-023 an SHALL be ~(4'b0001 << digit index); exactly one bit low at all times after reset.
REQ-024 seg for the lit digit SHALL be: entry vld=0 -> 8'hFF; vld=1, any=0 -> 8'hBF ('-'); vld=1, any=1 -> glyph of code.
REQ-025 Glyphs SHALL be 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 (hex).
REQ-026 When digit index=0 and entry 0 vld=1, seg bit 7 (dp) SHALL be 0, marking the newest result.
REQ-027 seg and an SHALL be registered outputs (one cycle after digit index/entry change).
REQ-028 in_code and in_any SHALL be ignored in cycles without accept.

Reset
REQ-029 While rst=0 at a clock edge: history all vld=0, FSM IDLE, hold counter 0, acc_cnt 0, divider 0, digit index 0, seg 8'hFF, an 4'b1110.
REQ-030 in_ready SHALL read 0 while rst=0 and 1 the first cycle after release.
REQ-031 Reset asserted mid-HOLD or mid-scan SHALL abandon the operation; no partial entry is retained.

Structure
REQ-032 Glyph constants, blank/dash constants and the FSM state enum SHALL live in shared package enc_seg_pkg.
REQ-033 The code-to-glyph lookup SHALL be one combinational sub-module, seg_glyph (in: any, code; out: 8-bit seg pattern without dp).
REQ-034 The block SHALL contain no latches and no second clock.

Verification
REQ-035 Reset release, no input -> an cycles 1110,1101,1011,0111 every SCAN_DIV cycles; seg stays FF; acc_cnt=0.
REQ-036 Accept code=5,any=1 (HOLD=4) -> in_ready low exactly 4 cycles; digit 0 shows 8'h12 (92 with dp); acc_cnt=1.
REQ-037 Accept 1,2,3,4,6 spaced by HOLD -> entries 0..3 show 82(+dp=02),99,B0,A4; code 1 discarded; acc_cnt=5.
REQ-038 Accept any=0,code=0 -> digit 0 shows 8'h3F ('-' with dp).
REQ-039 clr=1 in same cycle as in_valid=1 -> no accept, in_ready=0, all digits FF next scan, acc_cnt=0.
REQ-040 256 accepts -> acc_cnt wraps to 0; in_valid held high throughout never accepts while in_ready=0.
